sub_seq: RTL and testbench
==========================

# sub_seq

Multi-cycle unsigned/two's-complement subtractor computing `a - b` over N-bit operands. It processes CHUNK bits per clock, least-significant chunk first, and propagates a registered borrow between chunks. It is the inverse-operation companion to the combinational ripple `Add` block. Operands enter and results leave through valid/ready handshakes, so the block sits between an operand source and a result consumer in the datapath.

## Interface
Parameters:
- `N`, 32, operand/result width; must be a multiple of CHUNK.
- `CHUNK`, 8, bits subtracted per BUSY cycle. C = N/CHUNK is the number of chunk cycles; CHUNK = N gives C = 1.

Ports (one clock; reset is synchronous and active-high):
- `clk`  input  1  clock; all state updates on the rising edge.
- `rst`  input  1  synchronous active-high reset.
- `in_valid`  input  1  operand pair valid.
- `in_ready`  output  1  block can accept operands.
- `a`  input  N  minuend.
- `b`  input  N  subtrahend.
- `out_valid`  output  1  result valid.
- `out_ready`  input  1  consumer accepts result.
- `diff`  output  N  (a - b) mod 2^N.
- `borrow`  output  1  1 iff a < b (unsigned).
- `zero`, `neg`, `ovf`  output  1 each  present only with `SUB_SEQ_FLAGS_EN` (see Configuration).

## Operation
- FSM states: IDLE, BUSY, DONE. Registers: `a_q`, `b_q`, `diff_q`, `borrow_q`, chunk index `idx` (width clog2(C), minimum 1).
- IDLE:
  - `in_ready` = 1.
  - On `in_valid` & `in_ready`: capture `a`→`a_q` and `b`→`b_q`; clear `borrow_q`; set `idx` = 0; go to BUSY.
- BUSY:
  - `in_ready` = 0.
  - Each cycle computes `{bo, d} = a_q[idx*CHUNK +: CHUNK] - b_q[idx*CHUNK +: CHUNK] - borrow_q`, where d is CHUNK bits and bo is 1 bit.
  - Writes d into `diff_q` at chunk idx, sets `borrow_q` = bo, and increments `idx`.
  - After chunk C-1, goes to DONE.
- DONE:
  - `out_valid` = 1; `diff` and `borrow` hold the final values, stable until the handshake completes.
  - On `out_ready`, goes to IDLE.
- `in_valid` is ignored outside IDLE. Operands need only be held during the accepting cycle.
- `out_valid` = (state == DONE); `in_ready` = (state == IDLE) & ~rst.
- Arithmetic is exact modulo 2^N. The chunk-C-1 borrow is the final `borrow`.
- Reset:
  - state IDLE; `diff_q`, `borrow_q`, `idx`, `a_q`, `b_q` = 0.
  - Outputs `out_valid` = 0, `diff` = 0, `borrow` = 0, and flags = 0.
  - Reset during BUSY or DONE abandons the operation; no result is emitted.
  - `rst` takes priority over any simultaneous handshake.

## Timing
- Accept edge T0 (in_valid & in_ready). Chunk k is computed at edge T(k+1). `out_valid` rises after edge TC, so latency is C+1 cycles from the accept edge (5 cycles for defaults).
- The result is consumed at the first edge where `out_valid` & `out_ready` are both high. The next accept is possible one edge later.
- Minimum initiation interval is C+2 cycles. There is no back-to-back overlap.
- `out_ready` held low keeps the block in DONE indefinitely with all outputs constant.
- `out_ready` high before `out_valid` has no effect.

## Configuration
- `SUB_SEQ_FLAGS_EN` defined: adds registered outputs, valid with `out_valid` and held in DONE:
  - `zero` = (diff == 0).
  - `neg` = diff[N-1].
  - `ovf` = (a[N-1] != b[N-1]) & (diff[N-1] != a[N-1]), i.e. signed overflow.
- `SUB_SEQ_FLAGS_EN` undefined: the ports and their logic do not exist. All other behaviour and timing are identical.

## Test plan
- a=10, b=3, out_ready=1 → after C+1=5 cycles `out_valid`=1, diff=7, borrow=0; `in_ready` returns to 1 one cycle later.
- a=0, b=1 → diff=0xFFFFFFFF, borrow=1; with flags: neg=1, ovf=0, zero=0.
- a=0x80000000, b=1 → diff=0x7FFFFFFF, borrow=0, ovf=1. Also a=0x01000000, b=1 → diff=0x00FFFFFF, exercising borrow across three chunk boundaries.
- Backpressure: a=b=0x12345678, out_ready=0 for 6 cycles with in_valid=1 and new operands driven → diff=0, zero=1, `out_valid` held, `in_ready`=0, new operands not captured; out_ready=1 → one handshake, then IDLE.
- Reset mid-op: assert rst for one cycle at second BUSY cycle → next cycle out_valid=0, diff=0, borrow=0, in_ready=1. A following a=5, b=9 yields diff=0xFFFFFFFC, borrow=1.
- Parameter sweep: CHUNK=32 and CHUNK=1 (N=32), 1000 random pairs each → diff = a-b mod 2^32 and borrow = (a<b); latency 2 and 33 cycles respectively.

Source files
------------

// File: rtl/sub_seq_if.sv
// Operand/result handshake bundle for sub_seq. The zero/neg/ovf flag signals
// exist only when SUB_SEQ_FLAGS_EN is defined.
interface sub_seq_if #(
    parameter int N = 32
);
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] diff;
    logic         borrow;
`ifdef SUB_SEQ_FLAGS_EN
    logic         zero;
    logic         neg;
    logic         ovf;
`endif

`ifdef SUB_SEQ_FLAGS_EN
    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, diff, borrow, zero, neg, ovf
    );
    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, diff, borrow, zero, neg, ovf
    );
`else
    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, diff, borrow
    );
    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, diff, borrow
    );
`endif
endinterface

// File: rtl/sub_seq.sv
// Multi-cycle chunked subtractor: diff = a - b, CHUNK bits per clock, LS chunk first.
// Optional zero/neg/ovf result flags are enabled by defining SUB_SEQ_FLAGS_EN.
//
//   state | meaning
//   IDLE  | waiting for an operand pair (in_ready high)
//   BUSY  | subtracting one chunk per cycle, borrow carried in borrow_q
//   DONE  | result held on diff/borrow until out_ready
module sub_seq #(
    parameter int N     = 32,
    parameter int CHUNK = 8
) (
    input  logic     clk,
    input  logic     rst,
    sub_seq_if.slave bus
);
    localparam int C     = N / CHUNK;
    localparam int IDX_W = (C > 1) ? $clog2(C) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state;
    logic [N-1:0]     a_q;
    logic [N-1:0]     b_q;
    logic [N-1:0]     diff_q;
    logic             borrow_q;
    logic [IDX_W-1:0] idx;

    logic [CHUNK:0]   chunk_res;
    logic [N-1:0]     diff_nxt;
    logic             last_chunk;

    // Full-width view of the result after this cycle's chunk, so the flags can
    // be registered on the same edge that enters DONE.
    always_comb begin
        chunk_res = {1'b0, a_q[idx*CHUNK +: CHUNK]}
                  - {1'b0, b_q[idx*CHUNK +: CHUNK]}
                  - {{CHUNK{1'b0}}, borrow_q};
        diff_nxt = diff_q;
        diff_nxt[idx*CHUNK +: CHUNK] = chunk_res[CHUNK-1:0];
    end

    assign last_chunk = (idx == IDX_W'(C - 1));

`ifdef SUB_SEQ_FLAGS_EN
    logic zero_q;
    logic neg_q;
    logic ovf_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            idx      <= '0;
`ifdef SUB_SEQ_FLAGS_EN
            zero_q   <= 1'b0;
            neg_q    <= 1'b0;
            ovf_q    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_q      <= bus.a;
                        b_q      <= bus.b;
                        borrow_q <= 1'b0;
                        idx      <= '0;
                        state    <= BUSY;
                    end
                end
                BUSY: begin
                    diff_q   <= diff_nxt;
                    borrow_q <= chunk_res[CHUNK];
                    if (last_chunk) begin
                        // Parked at 0 so idx never selects past the operand.
                        idx   <= '0;
                        state <= DONE;
`ifdef SUB_SEQ_FLAGS_EN
                        zero_q <= (diff_nxt == '0);
                        neg_q  <= diff_nxt[N-1];
                        ovf_q  <= (a_q[N-1] != b_q[N-1]) && (diff_nxt[N-1] != a_q[N-1]);
`endif
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE) && !rst;
    assign bus.out_valid = (state == DONE);
    assign bus.diff      = diff_q;
    assign bus.borrow    = borrow_q;
`ifdef SUB_SEQ_FLAGS_EN
    assign bus.zero      = zero_q;
    assign bus.neg       = neg_q;
    assign bus.ovf       = ovf_q;
`endif
endmodule

// File: tb/tb_sub_seq.sv
// Directed bench for sub_seq: default CHUNK=8 instance plus CHUNK=32 and CHUNK=1 sweeps.
// Flag checks are compiled in when SUB_SEQ_FLAGS_EN is defined.
module tb_sub_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sub_seq_if #(.N(32)) if0 ();
    sub_seq_if #(.N(32)) if1 ();
    sub_seq_if #(.N(32)) if2 ();

    sub_seq #(.N(32), .CHUNK(8))  dut0 (.clk(clk), .rst(rst), .bus(if0));
    sub_seq #(.N(32), .CHUNK(32)) dut1 (.clk(clk), .rst(rst), .bus(if1));
    sub_seq #(.N(32), .CHUNK(1))  dut2 (.clk(clk), .rst(rst), .bus(if2));

    int checks   = 0;
    int failures = 0;

`ifdef SUB_SEQ_FLAGS_EN
    logic f_zero, f_neg, f_ovf;
`endif

    task automatic drive_in(input int sel, input logic v, input logic [31:0] av, input logic [31:0] bv);
        case (sel)
            0: begin if0.in_valid = v; if0.a = av; if0.b = bv; end
            1: begin if1.in_valid = v; if1.a = av; if1.b = bv; end
            default: begin if2.in_valid = v; if2.a = av; if2.b = bv; end
        endcase
    endtask

    task automatic set_ordy(input int sel, input logic v);
        case (sel)
            0: if0.out_ready = v;
            1: if1.out_ready = v;
            default: if2.out_ready = v;
        endcase
    endtask

    function automatic logic rd_ov(input int sel);
        case (sel)
            0: return if0.out_valid;
            1: return if1.out_valid;
            default: return if2.out_valid;
        endcase
    endfunction

    function automatic logic [31:0] rd_diff(input int sel);
        case (sel)
            0: return if0.diff;
            1: return if1.diff;
            default: return if2.diff;
        endcase
    endfunction

    function automatic logic rd_borrow(input int sel);
        case (sel)
            0: return if0.borrow;
            1: return if1.borrow;
            default: return if2.borrow;
        endcase
    endfunction

    // One full transaction with out_ready high; lat counts edges from the accept
    // edge (inclusive) until out_valid is seen, bounded at 64.
    task automatic run_op(input int sel, input logic [31:0] av, input logic [31:0] bv,
                          output logic [31:0] d, output logic bo, output int lat);
        set_ordy(sel, 1'b1);
        drive_in(sel, 1'b1, av, bv);
        @(posedge clk); #1;
        drive_in(sel, 1'b0, 32'h0, 32'h0);
        lat = 1;
        while (!rd_ov(sel) && lat < 64) begin
            @(posedge clk); #1;
            lat++;
        end
        d  = rd_diff(sel);
        bo = rd_borrow(sel);
`ifdef SUB_SEQ_FLAGS_EN
        if (sel == 0) begin
            f_zero = if0.zero; f_neg = if0.neg; f_ovf = if0.ovf;
        end
`endif
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (if0.in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready_during got=%b exp=0", if0.in_ready); end
        checks++; if (if0.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", if0.out_valid); end
        checks++; if (if0.diff !== 32'h0) begin failures++; $display("FAIL reset_diff got=%h exp=0", if0.diff); end
        checks++; if (if0.borrow !== 1'b0) begin failures++; $display("FAIL reset_borrow got=%b exp=0", if0.borrow); end
        rst = 1'b0;
        #1;
        checks++; if (if0.in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready_after got=%b exp=1", if0.in_ready); end
    endtask

    task automatic test_basic();
        logic [31:0] d; logic bo; int lat;
        run_op(0, 32'd10, 32'd3, d, bo, lat);
        checks++; if (d !== 32'd7) begin failures++; $display("FAIL basic_diff got=%h exp=7", d); end
        checks++; if (bo !== 1'b0) begin failures++; $display("FAIL basic_borrow got=%b exp=0", bo); end
        checks++; if (lat != 5) begin failures++; $display("FAIL basic_latency got=%0d exp=5", lat); end
        checks++; if (if0.in_ready !== 1'b1) begin failures++; $display("FAIL basic_in_ready_return got=%b exp=1", if0.in_ready); end
        checks++; if (if0.out_valid !== 1'b0) begin failures++; $display("FAIL basic_out_valid_drop got=%b exp=0", if0.out_valid); end
    endtask

    task automatic test_borrow_chain();
        logic [31:0] d; logic bo; int lat;
        run_op(0, 32'h0, 32'h1, d, bo, lat);
        checks++; if (d !== 32'hFFFF_FFFF) begin failures++; $display("FAIL under_diff got=%h exp=ffffffff", d); end
        checks++; if (bo !== 1'b1) begin failures++; $display("FAIL under_borrow got=%b exp=1", bo); end
`ifdef SUB_SEQ_FLAGS_EN
        checks++; if ({f_zero, f_neg, f_ovf} !== 3'b010) begin failures++; $display("FAIL under_flags got=%b exp=010", {f_zero, f_neg, f_ovf}); end
`endif
        run_op(0, 32'h8000_0000, 32'h1, d, bo, lat);
        checks++; if (d !== 32'h7FFF_FFFF) begin failures++; $display("FAIL ovf_diff got=%h exp=7fffffff", d); end
        checks++; if (bo !== 1'b0) begin failures++; $display("FAIL ovf_borrow got=%b exp=0", bo); end
`ifdef SUB_SEQ_FLAGS_EN
        checks++; if ({f_zero, f_neg, f_ovf} !== 3'b001) begin failures++; $display("FAIL ovf_flags got=%b exp=001", {f_zero, f_neg, f_ovf}); end
`endif
        run_op(0, 32'h0100_0000, 32'h1, d, bo, lat);
        checks++; if (d !== 32'h00FF_FFFF) begin failures++; $display("FAIL chain_diff got=%h exp=00ffffff", d); end
        checks++; if (bo !== 1'b0) begin failures++; $display("FAIL chain_borrow got=%b exp=0", bo); end
    endtask

    task automatic test_backpressure();
        int n;
        set_ordy(0, 1'b0);
        drive_in(0, 1'b1, 32'h1234_5678, 32'h1234_5678);
        @(posedge clk); #1;
        drive_in(0, 1'b1, 32'hDEAD_BEEF, 32'h0000_0001);
        n = 0;
        while (!if0.out_valid && n < 64) begin
            @(posedge clk); #1;
            n++;
        end
        checks++; if (n != 4) begin failures++; $display("FAIL bp_reach_done got=%0d exp=4", n); end
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            checks++;
            if (if0.out_valid !== 1'b1 || if0.in_ready !== 1'b0 || if0.diff !== 32'h0 || if0.borrow !== 1'b0) begin
                failures++;
                $display("FAIL bp_hold cyc=%0d got ov=%b ir=%b diff=%h bo=%b exp ov=1 ir=0 diff=0 bo=0",
                         i, if0.out_valid, if0.in_ready, if0.diff, if0.borrow);
            end
`ifdef SUB_SEQ_FLAGS_EN
            checks++; if (if0.zero !== 1'b1) begin failures++; $display("FAIL bp_zero got=%b exp=1", if0.zero); end
`endif
        end
        drive_in(0, 1'b0, 32'h0, 32'h0);
        set_ordy(0, 1'b1);
        @(posedge clk); #1;
        checks++; if (if0.out_valid !== 1'b0 || if0.in_ready !== 1'b1) begin failures++; $display("FAIL bp_release got ov=%b ir=%b exp ov=0 ir=1", if0.out_valid, if0.in_ready); end
        @(posedge clk); #1;
        checks++; if (if0.out_valid !== 1'b0 || if0.diff !== 32'h0) begin failures++; $display("FAIL bp_single_handshake got ov=%b diff=%h exp ov=0 diff=0", if0.out_valid, if0.diff); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d; logic bo; int lat;
        set_ordy(0, 1'b1);
        drive_in(0, 1'b1, 32'h0000_00FF, 32'h0000_0001);
        @(posedge clk); #1;
        drive_in(0, 1'b0, 32'h0, 32'h0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        checks++; if (if0.out_valid !== 1'b0) begin failures++; $display("FAIL rstmid_out_valid got=%b exp=0", if0.out_valid); end
        checks++; if (if0.diff !== 32'h0) begin failures++; $display("FAIL rstmid_diff got=%h exp=0", if0.diff); end
        checks++; if (if0.borrow !== 1'b0) begin failures++; $display("FAIL rstmid_borrow got=%b exp=0", if0.borrow); end
        checks++; if (if0.in_ready !== 1'b1) begin failures++; $display("FAIL rstmid_in_ready got=%b exp=1", if0.in_ready); end
        @(posedge clk); #1;
        checks++; if (if0.out_valid !== 1'b0) begin failures++; $display("FAIL rstmid_no_result got=%b exp=0", if0.out_valid); end
        run_op(0, 32'd5, 32'd9, d, bo, lat);
        checks++; if (d !== 32'hFFFF_FFFC) begin failures++; $display("FAIL rstmid_next_diff got=%h exp=fffffffc", d); end
        checks++; if (bo !== 1'b1) begin failures++; $display("FAIL rstmid_next_borrow got=%b exp=1", bo); end
        checks++; if (lat != 5) begin failures++; $display("FAIL rstmid_next_latency got=%0d exp=5", lat); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d; logic bo; int lat;
        run_op(0, 32'd100, 32'd1, d, bo, lat);
        checks++; if (d !== 32'd99 || bo !== 1'b0) begin failures++; $display("FAIL b2b_first got diff=%h bo=%b exp diff=63 bo=0", d, bo); end
        run_op(0, 32'h0000_0001, 32'h0000_0100, d, bo, lat);
        checks++; if (d !== 32'hFFFF_FF01 || bo !== 1'b1) begin failures++; $display("FAIL b2b_second got diff=%h bo=%b exp diff=ffffff01 bo=1", d, bo); end
        checks++; if (lat != 5) begin failures++; $display("FAIL b2b_latency got=%0d exp=5", lat); end
    endtask

    task automatic test_sweep(input int sel, input int exp_lat);
        logic [31:0] av, bv, d; logic bo; int lat;
        for (int i = 0; i < 1000; i++) begin
            av = $urandom;
            bv = (i % 50 == 0) ? av : $urandom;
            run_op(sel, av, bv, d, bo, lat);
            checks++;
            if (d !== av - bv || bo !== (av < bv) || lat != exp_lat) begin
                failures++;
                $display("FAIL sweep sel=%0d a=%h b=%h got diff=%h bo=%b lat=%0d exp diff=%h bo=%b lat=%0d",
                         sel, av, bv, d, bo, lat, av - bv, (av < bv), exp_lat);
            end
        end
    endtask

    initial begin
        for (int s = 0; s < 3; s++) begin
            drive_in(s, 1'b0, 32'h0, 32'h0);
            set_ordy(s, 1'b0);
        end
        test_reset();
        test_basic();
        test_borrow_chain();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        test_sweep(1, 2);
        test_sweep(2, 33);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
